// File: rtl/program_loader_pkg.sv
// Shared types and constants for the program loader: FSM states and stream framing sizes.
package loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam int LEN_BYTES  = 2;
    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream link plus instruction-memory write port.
// master = the loader (consumes bytes, drives imem writes); slave = host/memory side.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8
) ();

    logic                  rx_valid;
    logic [7:0]            rx_data;
    logic                  rx_ready;
    logic                  imem_we;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_wdata;

    modport master (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/program_loader_word_packer.sv
// Shifts stream bytes in MSB-first and flags the completed 32-bit word on every 4th byte.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [23:0] shreg;
    logic [1:0]  cnt;

    // The word is presented combinationally so the caller can register it on the accepting edge.
    assign word_valid = byte_valid && (cnt == 2'(WORD_BYTES - 1));
    assign word       = {shreg, byte_in};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (byte_valid) begin
            shreg <= {shreg[15:0], byte_in};
            cnt   <= cnt + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction memory,
// holding the core in reset until a complete image verifies.
module program_loader
    import loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    program_loader_if.master bus,
    output logic             core_reset,
    output logic             done,
    output logic             error
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int LEN_W = 8 * LEN_BYTES;

    state_t           state;
    logic [7:0]       len_hi;
    logic [LEN_W-1:0] n_words;
    logic [CNT_W-1:0] word_cnt;
    logic [7:0]       run_xor;

    logic             accept;
    logic             session_start;
    logic             pk_valid;
    logic [31:0]      pk_word;
    logic [LEN_W-1:0] len_full;
    logic             len_too_big;
    logic             last_word;

    assign accept        = bus.rx_valid && bus.rx_ready;
    assign session_start = start && ((state == IDLE) || (state == DONE) || (state == ERROR));
    assign len_full      = {len_hi, bus.rx_data};
    // Compared at 32 bits so 2^ADDR_WIDTH is representable for any supported width.
    assign len_too_big   = 32'(len_full) > (32'd1 << ADDR_WIDTH);
    assign last_word     = (32'(word_cnt) + 32'd1) == 32'(n_words);

    word_packer u_packer (
        .clk        (clk),
        .reset_n    (reset_n),
        .clear      (session_start),
        .byte_valid (accept && (state == DATA)),
        .byte_in    (bus.rx_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            len_hi         <= '0;
            n_words        <= '0;
            word_cnt       <= '0;
            run_xor        <= '0;
            bus.rx_ready   <= 1'b0;
            bus.imem_we    <= 1'b0;
            bus.imem_addr  <= '0;
            bus.imem_wdata <= '0;
            core_reset     <= 1'b1;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            bus.imem_we <= 1'b0;
            if (accept) begin
                run_xor <= run_xor ^ bus.rx_data;
            end
            case (state)
                IDLE, DONE, ERROR: begin
                    if (start) begin
                        state        <= LEN_HI;
                        bus.rx_ready <= 1'b1;
                        core_reset   <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        run_xor      <= '0;
                        word_cnt     <= '0;
                    end
                end
                LEN_HI: begin
                    if (accept) begin
                        len_hi <= bus.rx_data;
                        state  <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (accept) begin
                        n_words <= len_full;
                        if (len_too_big) begin
                            state        <= ERROR;
                            bus.rx_ready <= 1'b0;
                            error        <= 1'b1;
                        end else if (len_full == '0) begin
                            state <= CSUM;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (pk_valid) begin
                        bus.imem_we    <= 1'b1;
                        bus.imem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                        bus.imem_wdata <= pk_word;
                        word_cnt       <= word_cnt + 1'b1;
                        if (last_word) begin
                            state <= CSUM;
                        end
                    end
                end
                CSUM: begin
                    if (accept) begin
                        bus.rx_ready <= 1'b0;
                        if (bus.rx_data == run_xor) begin
                            state      <= DONE;
                            done       <= 1'b1;
                            core_reset <= 1'b0;
                        end else begin
                            state <= ERROR;
                            error <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: full-rate, gapped, empty, bad-checksum, bad-length,
// maximum-length and mid-session reset loads.
module tb_program_loader;

    logic clk;
    logic reset_n;
    logic start;
    logic core_reset;
    logic done;
    logic error;

    int total = 0;
    int bad   = 0;

    logic [31:0] img[$];
    logic [7:0]  wr_addr[$];
    logic [31:0] wr_data[$];

    program_loader_if #(.ADDR_WIDTH(8)) bus ();

    program_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .bus        (bus),
        .core_reset (core_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.imem_we === 1'b1) begin
            wr_addr.push_back(bus.imem_addr);
            wr_data.push_back(bus.imem_wdata);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gappy);
        int waited = 0;
        if (gappy) begin
            while ($urandom_range(0, 2) == 0) begin
                bus.rx_valid = 1'b0;
                @(negedge clk);
            end
        end
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (bus.rx_ready !== 1'b1) begin
            check("rx_ready_timeout", {31'b0, bus.rx_ready}, 32'd1);
            bus.rx_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_image(input logic [15:0] len, input logic [7:0] csum,
                              input bit gappy, input bit mid_start);
        logic [31:0] w;
        send_byte(len[15:8], gappy);
        send_byte(len[7:0], gappy);
        for (int i = 0; i < int'(len); i++) begin
            w = img[i];
            for (int j = 0; j < 4; j++) begin
                send_byte(w[31-8*j -: 8], gappy);
                if (mid_start && i == 1 && j == 3) begin
                    bus.rx_valid = 1'b0;
                    pulse_start();
                    check("mid_start_ignored_ready", {31'b0, bus.rx_ready}, 32'd1);
                    check("mid_start_ignored_reset", {31'b0, core_reset}, 32'd1);
                end
            end
        end
        send_byte(csum, gappy);
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_count"}, wr_addr.size(), n);
        for (int i = 0; i < n && i < wr_addr.size(); i++) begin
            check({tag, "_addr"}, {24'b0, wr_addr[i]}, i);
            check({tag, "_data"}, wr_data[i], img[i]);
        end
    endtask

    task automatic load_vector_image();
        img = '{32'h00221820, 32'h00612022, 32'hAC040004, 32'h8C050004, 32'h10850004};
    endtask

    task automatic check_done(input string tag);
        check({tag, "_done"},       {31'b0, done},        32'd1);
        check({tag, "_error"},      {31'b0, error},       32'd0);
        check({tag, "_core_reset"}, {31'b0, core_reset},  32'd0);
        check({tag, "_rx_ready"},   {31'b0, bus.rx_ready}, 32'd0);
        check({tag, "_we_idle"},    {31'b0, bus.imem_we}, 32'd0);
    endtask

    task automatic new_session();
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        check("session_rx_ready", {31'b0, bus.rx_ready}, 32'd1);
        check("session_core_reset", {31'b0, core_reset}, 32'd1);
        check("session_done_clear", {31'b0, done}, 32'd0);
        check("session_error_clear", {31'b0, error}, 32'd0);
    endtask

    initial begin
        clk          = 1'b0;
        reset_n      = 1'b1;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;

        #2 reset_n = 1'b0;
        #1;
        check("rst_rx_ready",   {31'b0, bus.rx_ready}, 32'd0);
        check("rst_imem_we",    {31'b0, bus.imem_we},  32'd0);
        check("rst_imem_addr",  {24'b0, bus.imem_addr}, 32'd0);
        check("rst_imem_wdata", bus.imem_wdata, 32'd0);
        check("rst_core_reset", {31'b0, core_reset}, 32'd1);
        check("rst_done",       {31'b0, done},  32'd0);
        check("rst_error",      {31'b0, error}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_rx_ready", {31'b0, bus.rx_ready}, 32'd0);

        // Full-rate 5-word image
        load_vector_image();
        new_session();
        send_image(16'd5, 8'hCC, 1'b0, 1'b0);
        check_done("full");
        check_writes("full", 5);

        // Same image with gaps and an ignored mid-DATA start
        new_session();
        send_image(16'd5, 8'hCC, 1'b1, 1'b1);
        check_done("gappy");
        check_writes("gappy", 5);

        // Empty image
        img.delete();
        new_session();
        send_image(16'd0, 8'h00, 1'b0, 1'b0);
        check_done("empty");
        repeat (2) @(negedge clk);
        check("empty_count", wr_addr.size(), 0);

        // Bad checksum
        load_vector_image();
        new_session();
        send_image(16'd5, 8'hCD, 1'b0, 1'b0);
        check("badcs_error", {31'b0, error}, 32'd1);
        check("badcs_done", {31'b0, done}, 32'd0);
        check("badcs_core_reset", {31'b0, core_reset}, 32'd1);
        check("badcs_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
        check_writes("badcs", 5);

        // Recovery after error
        new_session();
        send_image(16'd5, 8'hCC, 1'b0, 1'b0);
        check_done("recover");
        check_writes("recover", 5);

        // Oversized length
        new_session();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        check("biglen_error", {31'b0, error}, 32'd1);
        check("biglen_rx_ready", {31'b0, bus.rx_ready}, 32'd0);
        check("biglen_core_reset", {31'b0, core_reset}, 32'd1);
        check("biglen_done", {31'b0, done}, 32'd0);
        repeat (5) @(negedge clk);
        check("biglen_count", wr_addr.size(), 0);

        // Maximum length 256: bytes k, ~k, 00, A5 each XOR to zero over 256 words,
        // so the checksum is just the length bytes 01^00.
        img.delete();
        for (int k = 0; k < 256; k++) begin
            img.push_back({8'(k), ~8'(k), 8'h00, 8'hA5});
        end
        new_session();
        send_image(16'h0100, 8'h01, 1'b0, 1'b0);
        check_done("maxlen");
        check_writes("maxlen", 256);
        if (wr_addr.size() == 256) begin
            check("maxlen_last_addr", {24'b0, wr_addr[255]}, 32'd255);
            check("maxlen_last_data", wr_data[255], 32'hFF00_00A5);
        end

        // Reset mid-DATA after 6 payload bytes
        load_vector_image();
        new_session();
        send_byte(8'h00, 1'b0);
        send_byte(8'h05, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h18, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h61, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midrst_rx_ready",   {31'b0, bus.rx_ready}, 32'd0);
        check("midrst_imem_we",    {31'b0, bus.imem_we},  32'd0);
        check("midrst_imem_addr",  {24'b0, bus.imem_addr}, 32'd0);
        check("midrst_imem_wdata", bus.imem_wdata, 32'd0);
        check("midrst_core_reset", {31'b0, core_reset}, 32'd1);
        check("midrst_done",       {31'b0, done},  32'd0);
        check("midrst_error",      {31'b0, error}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        check_writes("midrst", 1);

        new_session();
        send_image(16'd5, 8'hCC, 1'b0, 1'b0);
        check_done("postrst");
        check_writes("postrst", 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/program_loader.md
# program_loader

Streams a program image from a byte-wide host link into instruction memory while holding the processor core in reset. The loader is the writer side of the instruction-memory port: the core only reads that port, and the loader only writes it. It sits between an external byte source (UART/debug bridge) and the core's `reset` input. It releases the core only after it has received a complete image that passes the checksum.

## Interface
- `ADDR_WIDTH`, default 8: word-address width of instruction memory; capacity is 2^ADDR_WIDTH words (256 by default).
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a load session.
- `rx_valid`  in  1  byte available on `rx_data`.
- `rx_data`  in  8  stream byte.
- `rx_ready`  out  1  loader accepts a byte this cycle.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_WIDTH  word address of the write.
- `imem_wdata`  out  32  instruction word.
- `core_reset`  out  1  active-high reset to the core.
- `done`  out  1  the image loaded and verified; the core is running.
- `error`  out  1  the session failed (bad length or bad checksum).

## Operation
- Stream format, big-endian throughout:
  - 2 length bytes give the word count N.
  - 4·N payload bytes follow, most significant byte first; word k is written to address k.
  - 1 checksum byte follows, equal to the XOR of every preceding byte, length bytes included.
- A byte is accepted on a rising edge where `rx_valid && rx_ready`.
- States:
  - IDLE: the state after reset. `rx_ready` = 0. `start` → LEN_HI.
  - LEN_HI: accept a byte → LEN_LO.
  - LEN_LO: accept a byte, which completes N.
    - N > 2^ADDR_WIDTH → ERROR.
    - N = 0 → CSUM.
    - Otherwise → DATA.
  - DATA: accept bytes; every 4th byte completes a word. After word N−1 → CSUM.
  - CSUM: accept a byte.
    - Byte equals the running XOR → DONE.
    - Otherwise → ERROR.
  - DONE: `done` = 1, `core_reset` = 0. `start` → LEN_HI.
  - ERROR: `error` = 1, `core_reset` = 1. `start` → LEN_HI.
- `rx_ready` = 1 exactly in LEN_HI, LEN_LO, DATA and CSUM.
- `start` is ignored in LEN_HI, LEN_LO, DATA and CSUM.
- On entry to LEN_HI from DONE or ERROR:
  - `core_reset` re-asserts and `done`/`error` clear on that same edge.
  - The running XOR, byte counter and word counter clear.
- Arithmetic:
  - N is 16 bits and is compared against 2^ADDR_WIDTH at full width.
  - The word counter is ADDR_WIDTH+1 bits so that N = 2^ADDR_WIDTH terminates without wrap.
  - The byte counter is 2 bits and wraps every 4 bytes.

## Timing
- Reset values: `rx_ready` 0, `imem_we` 0, `imem_addr` 0, `imem_wdata` 0, `core_reset` 1, `done` 0, `error` 0; state IDLE.
- `start` sampled high in IDLE: `rx_ready` = 1 from the next cycle.
- Word write: all three write outputs are registered.
  - `imem_we`, `imem_addr` and `imem_wdata` are valid for exactly one cycle.
  - That cycle immediately follows the edge that accepted the word's 4th byte.
  - A new byte may be accepted in that same cycle; there is no stall and no bubble.
- Full rate: one byte per cycle sustained. `rx_valid` gaps only delay progress and never alter the result.
- Checksum byte accepted on edge E:
  - DONE/ERROR, `done`/`error` and `core_reset` all update on edge E.
  - The last `imem_we` pulse always precedes E by at least one cycle.
- Length error: `error` = 1 and `rx_ready` = 0 from the edge that accepted the second length byte; no `imem_we` pulses occur.
- `reset_n` low mid-session: all outputs take reset values immediately, without waiting for `clk`. A partially assembled word is discarded and never written.

## Structure
- Shared package `loader_pkg`:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA, CSUM, DONE, ERROR);
  - `LEN_BYTES = 2`, `WORD_BYTES = 4`.
- Sub-module `word_packer`:
  - shifts in bytes MSB-first and holds the 2-bit byte counter;
  - pulses `word_valid` with a 32-bit word on every 4th byte;
  - has a synchronous `clear` input.
- Top level holds the FSM, word counter, running XOR, length compare and output registers.

## Test plan
- Load the N = 5 image 00221820, 00612022, AC040004, 8C050004, 10850004 with checksum 0xCC at full rate.
  - Required: 5 `imem_we` pulses at addresses 0–4 with those words.
  - Required: `done` = 1 and `core_reset` = 0 on the edge accepting 0xCC.
- Same image with `rx_valid` dropped on random cycles, plus a `start` pulse mid-DATA → identical writes and `done`; the mid-DATA `start` is ignored.
- Length 0x0000, checksum 0x00 → no writes; `done` = 1.
- Same 5-word image with checksum 0xCD → 5 writes; then `error` = 1, `core_reset` stays 1, `done` = 0.
  - A following `start` plus a valid image → `done`, `error` = 0.
- Length 0x0101 with ADDR_WIDTH 8 → `error` = 1 after the second byte, `rx_ready` = 0, zero writes.
  - Length 0x0100 is accepted and ends with the address-255 write and `done`.
- `reset_n` pulsed low after 6 payload bytes → outputs at reset values asynchronously and no write of the partial word; a subsequent full load succeeds.
